// File: rtl/ifm_window_streamer.sv
// Raster-order IFM reader feeding the conv line buffer.
// Flags cycles where the line buffer taps hold a full window.
module ifm_window_streamer #(
  parameter int DATA_WIDTH  = 32,
  parameter int IFM_SIZE    = 28,
  parameter int KERNAL_SIZE = 5,
  parameter int ADDR_WIDTH  = 10,
  parameter int OUT_SIZE    = IFM_SIZE - KERNAL_SIZE + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stall,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic                  fifo_enable,
  output logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  window_valid,
  output logic [7:0]            out_row,
  output logic [7:0]            out_col,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
    ADDR_WIDTH'(IFM_SIZE * IFM_SIZE - 1);
  localparam logic [7:0] KM1   = 8'(KERNAL_SIZE - 1);
  localparam logic [7:0] ILAST = 8'(IFM_SIZE - 1);
  localparam logic [7:0] OLAST = 8'(OUT_SIZE - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rd_valid_q;
  logic [7:0]            row_q, row_d;
  logic [7:0]            col_q, col_d;
  logic [7:0]            orow_q, orow_d;
  logic [7:0]            ocol_q, ocol_d;
  logic                  wv_q, wv_d;
  logic                  last_q, last_d;
  logic                  go;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    go      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          go      = 1'b1;
          state_d = FETCH;
          addr_d  = '0;
        end
      end
      FETCH: begin
        if (!stall) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          if (addr_q == LAST_ADDR) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (last_q) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Validity comes purely from the pixel counters, never from tap contents
  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    orow_d = orow_q;
    ocol_d = ocol_q;
    wv_d   = rd_valid_q && (row_q >= KM1) && (col_q >= KM1);
    last_d = wv_d && ((row_q - KM1) == OLAST)
                  && ((col_q - KM1) == OLAST);
    if (wv_d) begin
      orow_d = row_q - KM1;
      ocol_d = col_q - KM1;
    end
    if (go) begin
      row_d = '0;
      col_d = '0;
    end else if (rd_valid_q) begin
      if (col_q == ILAST) begin
        col_d = '0;
        row_d = row_q + 8'd1;
      end else begin
        col_d = col_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rd_valid_q <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      orow_q     <= '0;
      ocol_q     <= '0;
      wv_q       <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rd_valid_q <= ram_rd_en;
      row_q      <= row_d;
      col_q      <= col_d;
      orow_q     <= orow_d;
      ocol_q     <= ocol_d;
      wv_q       <= wv_d;
      last_q     <= last_d;
    end
  end

  assign ram_rd_en     = (state_q == FETCH) && !stall;
  assign ram_addr      = addr_q;
  assign fifo_enable   = rd_valid_q;
  assign fifo_data_out = rd_valid_q ? ram_data : '0;
  assign window_valid  = wv_q;
  assign out_row       = orow_q;
  assign out_col       = ocol_q;
  assign busy          = (state_q == FETCH) || (state_q == DRAIN);
  assign done          = (state_q == DONE);

endmodule

// File: tb/tb_ifm_window_streamer.sv
// Bench for ifm_window_streamer: default 28/5 instance plus a 6/3 instance.
// Expected timing is rebuilt from the stall pattern and raster arithmetic.
module tb_ifm_window_streamer;
  localparam int DW = 32;
  localparam int IFM = 28;
  localparam int K = 5;
  localparam int AW = 10;
  localparam int OUT = IFM - K + 1;
  localparam int N = IFM * IFM;
  localparam int BUDGET = 3000;

  logic clk = 0, reset = 1, start = 0, stall = 0;
  logic ram_rd_en, fifo_enable, window_valid, busy, done;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data, fifo_data_out;
  logic [7:0] out_row, out_col;

  logic s_start = 0, s_stall = 0;
  logic s_ram_rd_en, s_fifo_enable, s_window_valid, s_busy, s_done;
  logic [5:0] s_ram_addr;
  logic [31:0] s_ram_data, s_fifo_data_out;
  logic [7:0] s_out_row, s_out_col;

  int vectors = 0, fails = 0;
  int cyc = 0, t0 = 0;
  logic [31:0] salt = 0;
  bit mon_en = 0;
  int rd_a[$], rd_t[$], pu_d[$], pu_t[$];
  int wv_r[$], wv_c[$], wv_t[$], wv_p[$], dn_t[$];
  int hold_viol = 0, stall_viol = 0, busy_n = 0, last_px = 0;
  logic prev_stall = 0;
  logic [7:0] prev_r = 0, prev_c = 0;
  bit stall_at[0:BUDGET-1];

  ifm_window_streamer dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .ram_rd_en(ram_rd_en), .ram_addr(ram_addr), .ram_data(ram_data),
    .fifo_enable(fifo_enable), .fifo_data_out(fifo_data_out),
    .window_valid(window_valid), .out_row(out_row), .out_col(out_col),
    .busy(busy), .done(done)
  );

  ifm_window_streamer #(
    .DATA_WIDTH(32), .IFM_SIZE(6), .KERNAL_SIZE(3), .ADDR_WIDTH(6)
  ) s_dut (
    .clk(clk), .reset(reset), .start(s_start), .stall(s_stall),
    .ram_rd_en(s_ram_rd_en), .ram_addr(s_ram_addr), .ram_data(s_ram_data),
    .fifo_enable(s_fifo_enable), .fifo_data_out(s_fifo_data_out),
    .window_valid(s_window_valid), .out_row(s_out_row), .out_col(s_out_col),
    .busy(s_busy), .done(s_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ram_rd_en) ram_data <= 32'(ram_addr) + salt;
  always @(posedge clk) if (s_ram_rd_en) s_ram_data <= 32'(s_ram_addr) * 7 + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (ram_rd_en) begin
        rd_a.push_back(int'(ram_addr));
        rd_t.push_back(cyc - t0);
      end
      if (window_valid) begin
        wv_r.push_back(int'(out_row));
        wv_c.push_back(int'(out_col));
        wv_t.push_back(cyc - t0);
        wv_p.push_back(last_px);
      end else if (out_row !== prev_r || out_col !== prev_c) begin
        hold_viol <= hold_viol + 1;
      end
      if (fifo_enable) begin
        pu_d.push_back(int'(fifo_data_out - salt));
        pu_t.push_back(cyc - t0);
        last_px <= int'(fifo_data_out - salt);
        if (prev_stall) stall_viol <= stall_viol + 1;
      end
      if (done) dn_t.push_back(cyc - t0);
      if (busy) busy_n <= busy_n + 1;
    end
    prev_stall <= stall;
    prev_r <= out_row;
    prev_c <= out_col;
  end

  task automatic run_frame(input int mode, input bit extra, input string tag);
    int rel, t, h0, s0, b0, dexp, dgot;
    bit fin;
    int er[$], ew_r[$], ew_c[$], ew_t[$], ew_p[$];
    rd_a.delete(); rd_t.delete(); pu_d.delete(); pu_t.delete();
    wv_r.delete(); wv_c.delete(); wv_t.delete(); wv_p.delete();
    dn_t.delete();
    h0 = hold_viol; s0 = stall_viol; b0 = busy_n;
    t0 = cyc; mon_en = 1; rel = 0; fin = 0;
    while (!fin && rel < BUDGET) begin
      start = (rel == 0) || (extra && (rel == 100 || rel == 787));
      if (dn_t.size() > 0 || mode == 0) stall = 0;
      else if (rel < 50) stall = 0;
      else if (rel < 60) stall = 1;
      else stall = ($urandom_range(0, 99) < 30);
      stall_at[rel] = stall;
      @(posedge clk); #1; rel++;
      if (dn_t.size() > 0 && rel == dn_t[0] + 1) begin
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          fails++;
          $display("FAIL %s idle_after_done: busy=%0b done=%0b required 0 0",
                   tag, busy, done);
        end
      end
      if (dn_t.size() > 0 && rel == dn_t[0] + 2) fin = 1;
    end
    start = 0; stall = 0; mon_en = 0;
    if (!fin) begin
      fails++;
      $display("FAIL %s timeout: no done within %0d cycles", tag, BUDGET);
    end
    // reads occupy the first N unstalled cycles from cycle 1
    t = 1;
    while (er.size() < N && t < BUDGET) begin
      if (!stall_at[t]) er.push_back(t);
      t++;
    end
    while (er.size() < N) er.push_back(-1);
    for (int p = 0; p < N; p++) begin
      if (p / IFM >= K - 1 && p % IFM >= K - 1) begin
        ew_r.push_back(p / IFM - (K - 1));
        ew_c.push_back(p % IFM - (K - 1));
        ew_t.push_back(er[p] + 2);
        ew_p.push_back(p);
      end
    end
    vectors++;
    if (rd_a.size() != N) begin
      fails++;
      $display("FAIL %s read_count: got %0d required %0d", tag, rd_a.size(), N);
    end
    for (int i = 0; i < rd_a.size() && i < N; i++) begin
      vectors++;
      if (rd_a[i] !== i || rd_t[i] !== er[i]) begin
        fails++;
        $display("FAIL %s read[%0d]: addr=%0d cyc=%0d required addr=%0d cyc=%0d",
                 tag, i, rd_a[i], rd_t[i], i, er[i]);
      end
    end
    vectors++;
    if (pu_d.size() != N) begin
      fails++;
      $display("FAIL %s push_count: got %0d required %0d", tag, pu_d.size(), N);
    end
    for (int i = 0; i < pu_d.size() && i < N; i++) begin
      vectors++;
      if (pu_d[i] !== i || pu_t[i] !== er[i] + 1) begin
        fails++;
        $display("FAIL %s push[%0d]: data=%0d cyc=%0d required data=%0d cyc=%0d",
                 tag, i, pu_d[i], pu_t[i], i, er[i] + 1);
      end
    end
    vectors++;
    if (wv_r.size() != OUT * OUT) begin
      fails++;
      $display("FAIL %s window_count: got %0d required %0d",
               tag, wv_r.size(), OUT * OUT);
    end
    for (int i = 0; i < wv_r.size() && i < OUT * OUT; i++) begin
      vectors++;
      if (wv_r[i] !== ew_r[i] || wv_c[i] !== ew_c[i] ||
          wv_t[i] !== ew_t[i] || wv_p[i] !== ew_p[i]) begin
        fails++;
        $display("FAIL %s window[%0d]: (%0d,%0d) cyc=%0d px=%0d required (%0d,%0d) cyc=%0d px=%0d",
                 tag, i, wv_r[i], wv_c[i], wv_t[i], wv_p[i],
                 ew_r[i], ew_c[i], ew_t[i], ew_p[i]);
      end
    end
    dexp = er[N-1] + 3;
    dgot = (dn_t.size() > 0) ? dn_t[0] : -1;
    vectors++;
    if (dn_t.size() != 1 || dgot !== dexp) begin
      fails++;
      $display("FAIL %s done: pulses=%0d cyc=%0d required pulses=1 cyc=%0d",
               tag, dn_t.size(), dgot, dexp);
    end
    vectors++;
    if (busy_n - b0 !== dexp - 1) begin
      fails++;
      $display("FAIL %s busy_cycles: got %0d required %0d", tag, busy_n - b0, dexp - 1);
    end
    vectors++;
    if (stall_viol - s0 !== 0) begin
      fails++;
      $display("FAIL %s push_under_stall: got %0d required 0", tag, stall_viol - s0);
    end
    vectors++;
    if (hold_viol - h0 !== 0) begin
      fails++;
      $display("FAIL %s coord_hold: got %0d changes required 0", tag, hold_viol - h0);
    end
  endtask

  function automatic logic [62:0] outs();
    return {ram_rd_en, ram_addr, fifo_enable, fifo_data_out,
            window_valid, out_row, out_col, busy, done};
  endfunction

  task automatic test_reset();
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (outs() !== '0) begin
      fails++;
      $display("FAIL reset_hold: outputs=%h required 0", outs());
    end
    reset = 0;
    @(posedge clk); #1;
    vectors++;
    if (outs() !== '0) begin
      fails++;
      $display("FAIL after_reset: outputs=%h required 0", outs());
    end
    start = 1;
    for (int rel = 0; rel < 300; rel++) begin
      @(posedge clk); #1;
      start = 0;
    end
    vectors++;
    if (busy !== 1'b1 || ram_rd_en !== 1'b1) begin
      fails++;
      $display("FAIL midframe_active: busy=%0b rd_en=%0b required 1 1", busy, ram_rd_en);
    end
    reset = 1;
    #1;
    vectors++;
    if (outs() !== '0) begin
      fails++;
      $display("FAIL midframe_reset: outputs=%h required 0", outs());
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        fails++;
        $display("FAIL post_abort[%0d]: busy=%0b done=%0b required 0 0", i, busy, done);
      end
    end
  endtask

  task automatic test_full_frame();
    salt = 0;
    run_frame(0, 0, "full");
    vectors++;
    if (wv_t.size() == 0 || wv_t[0] !== 119 || wv_r[0] !== 0 || wv_c[0] !== 0) begin
      fails++;
      $display("FAIL first_window: n=%0d cyc=%0d required cyc=119 (0,0)",
               wv_t.size(), (wv_t.size() > 0) ? wv_t[0] : -1);
    end
    vectors++;
    if (wv_t.size() != 576 || wv_t[575] !== 786 || wv_r[575] !== 23 || wv_c[575] !== 23) begin
      fails++;
      $display("FAIL last_window: n=%0d required 576 at cyc 786 (23,23)", wv_t.size());
    end
    vectors++;
    if (wv_p.size() < 80 || wv_r[79] !== 3 || wv_c[79] !== 7 || wv_p[79] !== 207) begin
      fails++;
      $display("FAIL coord_3_7: n=%0d required (3,7) with pixel 207", wv_p.size());
    end
    vectors++;
    if (dn_t.size() != 1 || dn_t[0] !== 787) begin
      fails++;
      $display("FAIL done_787: n=%0d required single pulse at 787", dn_t.size());
    end
  endtask

  task automatic test_stall();
    salt = $urandom;
    run_frame(1, 0, "stall");
  endtask

  task automatic test_back_to_back();
    salt = $urandom;
    run_frame(0, 1, "ignored_starts");
    run_frame(0, 0, "second_frame");
    vectors++;
    if (dn_t.size() != 1 || dn_t[0] !== 787) begin
      fails++;
      $display("FAIL second_done: n=%0d required single pulse at 787", dn_t.size());
    end
  endtask

  task automatic test_small();
    int nr, np, nw, lastp, wt, dt, ndone;
    int ew_r[$], ew_c[$], ew_p[$];
    for (int p = 0; p < 36; p++) begin
      if (p / 6 >= 2 && p % 6 >= 2) begin
        ew_r.push_back(p / 6 - 2);
        ew_c.push_back(p % 6 - 2);
        ew_p.push_back(p);
      end
    end
    nr = 0; np = 0; nw = 0; lastp = -1; wt = -1; dt = -1; ndone = 0;
    s_start = 1;
    @(posedge clk); #1;
    s_start = 0;
    for (int k = 1; k < 120; k++) begin
      @(negedge clk);
      if (s_ram_rd_en) begin
        vectors++;
        if (s_ram_addr !== 6'(nr)) begin
          fails++;
          $display("FAIL small_read[%0d]: addr=%0d required %0d", nr, s_ram_addr, nr);
        end
        nr++;
      end
      if (s_window_valid) begin
        vectors++;
        if (nw >= 16 || s_out_row !== 8'(ew_r[nw]) ||
            s_out_col !== 8'(ew_c[nw]) || lastp !== ew_p[nw]) begin
          fails++;
          $display("FAIL small_window[%0d]: (%0d,%0d) px=%0d", nw, s_out_row, s_out_col, lastp);
        end
        nw++;
        wt = k;
      end
      if (s_fifo_enable) begin
        vectors++;
        if (s_fifo_data_out !== 32'(np * 7 + 1)) begin
          fails++;
          $display("FAIL small_push[%0d]: data=%0d required %0d",
                   np, s_fifo_data_out, np * 7 + 1);
        end
        lastp = np;
        np++;
      end
      if (s_done) begin
        ndone++;
        dt = k;
      end
    end
    vectors++;
    if (nr != 36 || np != 36 || nw != 16) begin
      fails++;
      $display("FAIL small_counts: reads=%0d pushes=%0d windows=%0d required 36 36 16",
               nr, np, nw);
    end
    vectors++;
    if (ndone != 1 || dt !== wt + 1 || s_busy !== 1'b0) begin
      fails++;
      $display("FAIL small_done: pulses=%0d cyc=%0d required 1 at %0d busy=%0b",
               ndone, dt, wt + 1, s_busy);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_stall();
    test_back_to_back();
    test_small();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
